// File: rtl/core_mac_seq_pkg.sv
// -----------------------------------------------------------------------------
// core_mac_seq_pkg
// Shared constants and types for the per-core MAC operand sequencer.
//   CORE_GBUS_ADDR : default core memory address width
//   CORE_CDATA_BIT : default width of the beats-per-row count
//   CORE_ROW_BIT   : default width of the rows-per-pass count
//   seq_state_e    : sequencer state encoding
// -----------------------------------------------------------------------------
package core_mac_seq_pkg;

    localparam int CORE_GBUS_ADDR = 12;
    localparam int CORE_CDATA_BIT = 8;
    localparam int CORE_ROW_BIT   = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } seq_state_e;

    // Total weight words fetched for one pass (beats per row times rows).
    function automatic logic [CORE_CDATA_BIT+CORE_ROW_BIT-1:0] pass_words(
        input logic [CORE_CDATA_BIT-1:0] acc_num,
        input logic [CORE_ROW_BIT-1:0]   row_num
    );
        return (CORE_CDATA_BIT+CORE_ROW_BIT)'(acc_num)
             * (CORE_CDATA_BIT+CORE_ROW_BIT)'(row_num);
    endfunction

endpackage

// File: rtl/core_wfetch.sv
// -----------------------------------------------------------------------------
// core_wfetch
// Weight prefetch engine: streams acc_num*row_num consecutive words from core
// memory into the local weight buffer, throttled by lbuf_almost_full.
// Ports:
//   clk, rstn            : clock, asynchronous active-low reset
//   load_i               : accepted pass start; loads address and word count
//   active_i             : pass in progress (fetching allowed)
//   cfg_acc_num_i        : beats per row
//   cfg_row_num_i        : rows per pass
//   cfg_wbase_i          : first weight address
//   lbuf_almost_full_i   : lbuf back-pressure
//   cmem_raddr_o         : current fetch address
//   cmem_ren_o           : fetch strobe
// -----------------------------------------------------------------------------
module core_wfetch
    import core_mac_seq_pkg::*;
#(
    parameter int GBUS_ADDR = CORE_GBUS_ADDR,
    parameter int CDATA_BIT = CORE_CDATA_BIT,
    parameter int ROW_BIT   = CORE_ROW_BIT
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 load_i,
    input  logic                 active_i,
    input  logic [CDATA_BIT-1:0] cfg_acc_num_i,
    input  logic [ROW_BIT-1:0]   cfg_row_num_i,
    input  logic [GBUS_ADDR-1:0] cfg_wbase_i,
    input  logic                 lbuf_almost_full_i,
    output logic [GBUS_ADDR-1:0] cmem_raddr_o,
    output logic                 cmem_ren_o
);

    localparam int REM_W = CDATA_BIT + ROW_BIT;

    logic [REM_W-1:0]     remain_q, remain_d;
    logic [GBUS_ADDR-1:0] raddr_q, raddr_d;
    logic                 fetch;

    // almost_full still leaves two free entries, so a word already in flight
    // from core memory always has room when it lands.
    assign fetch = active_i && (remain_q != '0) && !lbuf_almost_full_i;

    always_comb begin
        remain_d = remain_q;
        raddr_d  = raddr_q;
        if (load_i) begin
            remain_d = REM_W'(cfg_acc_num_i) * REM_W'(cfg_row_num_i);
            raddr_d  = cfg_wbase_i;
        end else if (fetch) begin
            remain_d = remain_q - REM_W'(1);
            // Address wraps naturally modulo 2^GBUS_ADDR.
            raddr_d  = raddr_q + GBUS_ADDR'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            remain_q <= '0;
            raddr_q  <= '0;
        end else begin
            remain_q <= remain_d;
            raddr_q  <= raddr_d;
        end
    end

    assign cmem_raddr_o = raddr_q;
    assign cmem_ren_o   = fetch;

endmodule

// File: rtl/core_mac_seq.sv
// -----------------------------------------------------------------------------
// core_mac_seq
// Per-core operand sequencer for one matrix-vector pass. Prefetches weights
// into lbuf, issues paired lbuf/abuf reads into the MAC one beat per cycle,
// replays the activation vector through the abuf reuse pointer for every row
// but the last, counts accumulator results and pulses done at the end.
// Ports:
//   clk, rstn                    : clock, asynchronous active-low reset
//   start                        : pass request, honoured only when idle
//   cfg_acc_num/row_num/wbase    : pass configuration, latched on start
//   cmem_raddr, cmem_ren         : weight fetch from core memory
//   lbuf_almost_full, lbuf_empty : weight buffer status
//   lbuf_ren                     : weight buffer read
//   abuf_empty, abuf_reuse_empty : activation buffer status
//   abuf_ren                     : consuming activation read (last row)
//   abuf_reuse_ren               : replay activation read (other rows)
//   abuf_reuse_rst               : rewind reuse pointer to normal pointer
//   acc_odata_valid              : one row result produced
//   busy, done                   : pass status
// -----------------------------------------------------------------------------
module core_mac_seq
    import core_mac_seq_pkg::*;
#(
    parameter int GBUS_ADDR = CORE_GBUS_ADDR,
    parameter int CDATA_BIT = CORE_CDATA_BIT,
    parameter int ROW_BIT   = CORE_ROW_BIT
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [CDATA_BIT-1:0] cfg_acc_num,
    input  logic [ROW_BIT-1:0]   cfg_row_num,
    input  logic [GBUS_ADDR-1:0] cfg_wbase,
    output logic [GBUS_ADDR-1:0] cmem_raddr,
    output logic                 cmem_ren,
    input  logic                 lbuf_almost_full,
    input  logic                 lbuf_empty,
    output logic                 lbuf_ren,
    input  logic                 abuf_empty,
    input  logic                 abuf_reuse_empty,
    output logic                 abuf_ren,
    output logic                 abuf_reuse_ren,
    output logic                 abuf_reuse_rst,
    input  logic                 acc_odata_valid,
    output logic                 busy,
    output logic                 done
);

    seq_state_e           state_q;
    logic [CDATA_BIT-1:0] acc_num_q;
    logic [CDATA_BIT-1:0] beat_q;
    logic [ROW_BIT-1:0]   row_num_q;
    logic [ROW_BIT-1:0]   row_q;
    logic [ROW_BIT-1:0]   out_cnt_q, out_cnt_d;
    logic                 busy_q;
    logic                 done_q;
    logic                 reuse_rst_q;

    logic start_ok;
    logic cfg_zero;
    logic last_row;
    logic next_row_replays;
    logic fire;
    logic beat_last;
    logic out_evt;

    assign start_ok  = start && (state_q == IDLE);
    assign cfg_zero  = (cfg_acc_num == '0) || (cfg_row_num == '0);
    assign last_row  = (row_q == (row_num_q - ROW_BIT'(1)));
    // Row about to be entered from a RUN row end is not the last one.
    assign next_row_replays = ((row_q + ROW_BIT'(1)) != (row_num_q - ROW_BIT'(1)));
    assign beat_last = (beat_q == (acc_num_q - CDATA_BIT'(1)));

    // Non-last rows read through the reuse pointer so the activation vector
    // stays in abuf; only the last row consumes it.
    assign fire = (state_q == RUN) && !lbuf_empty &&
                  (last_row ? !abuf_empty : !abuf_reuse_empty);

    assign lbuf_ren       = fire;
    assign abuf_ren       = fire && last_row;
    assign abuf_reuse_ren = fire && !last_row;
    assign abuf_reuse_rst = reuse_rst_q;
    assign busy           = busy_q;
    assign done           = done_q;

    // Result counter saturates at row_num; pulses outside the active states
    // are ignored.
    assign out_evt   = busy_q && acc_odata_valid && (out_cnt_q != row_num_q);
    assign out_cnt_d = out_cnt_q + ROW_BIT'(out_evt);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            acc_num_q   <= '0;
            row_num_q   <= '0;
            beat_q      <= '0;
            row_q       <= '0;
            out_cnt_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            reuse_rst_q <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            reuse_rst_q <= 1'b0;
            out_cnt_q   <= out_cnt_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_num_q <= cfg_acc_num;
                        row_num_q <= cfg_row_num;
                        beat_q    <= '0;
                        row_q     <= '0;
                        out_cnt_q <= '0;
                        if (cfg_zero) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q     <= ARM;
                            busy_q      <= 1'b1;
                            reuse_rst_q <= (cfg_row_num > ROW_BIT'(1));
                        end
                    end
                end
                ARM: begin
                    state_q <= RUN;
                end
                RUN: begin
                    if (fire) begin
                        if (beat_last) begin
                            beat_q <= '0;
                            if (last_row) begin
                                state_q <= DRAIN;
                            end else begin
                                row_q       <= row_q + ROW_BIT'(1);
                                state_q     <= ARM;
                                reuse_rst_q <= next_row_replays;
                            end
                        end else begin
                            beat_q <= beat_q + CDATA_BIT'(1);
                        end
                    end
                end
                DRAIN: begin
                    // Uses the updated count so the final pulse ends the
                    // pass in the same cycle it arrives.
                    if (out_cnt_d == row_num_q) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    core_wfetch #(
        .GBUS_ADDR (GBUS_ADDR),
        .CDATA_BIT (CDATA_BIT),
        .ROW_BIT   (ROW_BIT)
    ) u_wfetch (
        .clk                (clk),
        .rstn               (rstn),
        .load_i             (start_ok),
        .active_i           (busy_q),
        .cfg_acc_num_i      (cfg_acc_num),
        .cfg_row_num_i      (cfg_row_num),
        .cfg_wbase_i        (cfg_wbase),
        .lbuf_almost_full_i (lbuf_almost_full),
        .cmem_raddr_o       (cmem_raddr),
        .cmem_ren_o         (cmem_ren)
    );

endmodule

// File: tb/tb_core_mac_seq.sv
module tb_core_mac_seq;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  cfg_acc_num = '0;
    logic [7:0]  cfg_row_num = '0;
    logic [11:0] cfg_wbase = '0;
    logic [11:0] cmem_raddr;
    logic        cmem_ren;
    logic        lbuf_almost_full = 1'b0;
    logic        lbuf_empty = 1'b0;
    logic        lbuf_ren;
    logic        abuf_empty = 1'b0;
    logic        abuf_reuse_empty = 1'b0;
    logic        abuf_ren;
    logic        abuf_reuse_ren;
    logic        abuf_reuse_rst;
    logic        acc_odata_valid = 1'b0;
    logic        busy;
    logic        done;

    core_mac_seq dut (
        .clk              (clk),
        .rstn             (rstn),
        .start            (start),
        .cfg_acc_num      (cfg_acc_num),
        .cfg_row_num      (cfg_row_num),
        .cfg_wbase        (cfg_wbase),
        .cmem_raddr       (cmem_raddr),
        .cmem_ren         (cmem_ren),
        .lbuf_almost_full (lbuf_almost_full),
        .lbuf_empty       (lbuf_empty),
        .lbuf_ren         (lbuf_ren),
        .abuf_empty       (abuf_empty),
        .abuf_reuse_empty (abuf_reuse_empty),
        .abuf_ren         (abuf_ren),
        .abuf_reuse_ren   (abuf_reuse_ren),
        .abuf_reuse_rst   (abuf_reuse_rst),
        .acc_odata_valid  (acc_odata_valid),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err = 0;

    // Monitor state
    bit          mon_en = 1'b0;
    string       mon_log;
    int          n_lbuf, n_cmem, n_viol, n_addr_err, n_done, done_cyc;
    logic [11:0] exp_wbase;
    logic [11:0] last_addr;

    typedef struct {
        logic [7:0]  acc;
        logic [7:0]  row;
        logic [11:0] wbase;
        bit          toggle;
        bit          hold;
        bit          mid_start;
        int          exp_lbuf;
        int          exp_cmem;
        string       exp_log;
        logic [11:0] exp_last;
    } vec_t;

    vec_t vecs[6];

    task automatic set_vec(input int i, input logic [7:0] acc, input logic [7:0] row,
                           input logic [11:0] wbase, input bit tog, input bit hold,
                           input bit mid, input int el, input int ec, input string lg,
                           input logic [11:0] last);
        vecs[i].acc = acc;       vecs[i].row = row;     vecs[i].wbase = wbase;
        vecs[i].toggle = tog;    vecs[i].hold = hold;   vecs[i].mid_start = mid;
        vecs[i].exp_lbuf = el;   vecs[i].exp_cmem = ec; vecs[i].exp_log = lg;
        vecs[i].exp_last = last;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_str(input string name, input string act, input string exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got \"%s\", expected \"%s\"", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        mon_log = "";
        n_lbuf = 0; n_cmem = 0; n_viol = 0; n_addr_err = 0; n_done = 0;
        done_cyc = -1;
        last_addr = '0;
    endtask

    function automatic logic [18:0] out_bundle();
        return {busy, done, cmem_ren, lbuf_ren, abuf_ren, abuf_reuse_ren,
                abuf_reuse_rst, cmem_raddr};
    endfunction

    // Per-cycle observer, sampling well after the falling edge.
    always begin
        @(negedge clk);
        #2;
        if (mon_en) begin
            if (abuf_reuse_rst) mon_log = {mon_log, "R"};
            if (abuf_reuse_ren) mon_log = {mon_log, "r"};
            if (abuf_ren)       mon_log = {mon_log, "a"};
            if (lbuf_ren != (abuf_ren || abuf_reuse_ren)) mon_log = {mon_log, "X"};
            if (lbuf_ren) begin
                n_lbuf++;
                if (lbuf_empty) n_viol++;
            end
            if (cmem_ren) begin
                if (lbuf_almost_full) n_viol++;
                if (cmem_raddr !== exp_wbase + 12'(n_cmem)) n_addr_err++;
                last_addr = cmem_raddr;
                n_cmem++;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
        end
    end

    task automatic run_pass(input int i);
        vec_t v;
        int   t;
        int   guard;
        int   valid_cyc;
        v = vecs[i];
        valid_cyc = -100;
        @(negedge clk);
        clear_mon();
        exp_wbase   = v.wbase;
        cfg_acc_num = v.acc;
        cfg_row_num = v.row;
        cfg_wbase   = v.wbase;
        start       = 1'b1;
        mon_en      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check($sformatf("v%0d_busy_arm", i), 32'(busy), 32'd1);
        t = 1;
        guard = 0;
        while ((n_lbuf < v.exp_lbuf || n_cmem < v.exp_cmem) && guard < 300) begin
            lbuf_empty       = v.toggle && ((t % 2) == 1);
            lbuf_almost_full = v.hold && (t >= 3) && (t < 13);
            if (v.mid_start && t == 2) begin
                start = 1'b1; cfg_acc_num = 8'd7; cfg_row_num = 8'd7; cfg_wbase = 12'h500;
            end else begin
                start = 1'b0; cfg_acc_num = v.acc; cfg_row_num = v.row; cfg_wbase = v.wbase;
            end
            @(negedge clk);
            t++;
            guard++;
        end
        lbuf_empty = 1'b0;
        lbuf_almost_full = 1'b0;
        start = 1'b0;
        if (guard >= 300) begin
            n_checks++; n_err++;
            $display("FAIL v%0d_timeout: got lbuf=%0d cmem=%0d, expected %0d/%0d",
                     i, n_lbuf, n_cmem, v.exp_lbuf, v.exp_cmem);
        end
        #1;
        check($sformatf("v%0d_busy_drain", i), 32'(busy), 32'd1);
        for (int r = 0; r < int'(v.row); r++) begin
            @(negedge clk);
            @(negedge clk);
            acc_odata_valid = 1'b1;
            valid_cyc = cyc;
            @(negedge clk);
            acc_odata_valid = 1'b0;
        end
        repeat (3) @(negedge clk);
        #3;
        mon_en = 1'b0;
        check($sformatf("v%0d_lbuf_cnt", i), 32'(n_lbuf), 32'(v.exp_lbuf));
        check($sformatf("v%0d_cmem_cnt", i), 32'(n_cmem), 32'(v.exp_cmem));
        check_str($sformatf("v%0d_read_seq", i), mon_log, v.exp_log);
        check($sformatf("v%0d_addr_err", i), 32'(n_addr_err), 32'd0);
        check($sformatf("v%0d_strobe_viol", i), 32'(n_viol), 32'd0);
        check($sformatf("v%0d_last_addr", i), 32'(last_addr), 32'(v.exp_last));
        check($sformatf("v%0d_done_cnt", i), 32'(n_done), 32'd1);
        check($sformatf("v%0d_done_cyc", i), 32'(done_cyc), 32'(valid_cyc + 1));
        check($sformatf("v%0d_idle_after", i), 32'({busy, done}), 32'd0);
        $display("pass %0d: acc=%0d row=%0d wbase=%03h lbuf_ren=%0d cmem_ren=%0d seq=%s last_addr=%03h",
                 i, v.acc, v.row, v.wbase, n_lbuf, n_cmem, mon_log, last_addr);
    endtask

    initial begin
        //        idx acc    row    wbase    tog hold mid lbuf cmem  seq          last
        set_vec(0, 8'd4, 8'd1, 12'h010, 0, 0, 0, 4, 4, "aaaa",       12'h013);
        set_vec(1, 8'd2, 8'd3, 12'h100, 0, 0, 0, 6, 6, "RrrRrraa",   12'h105);
        set_vec(2, 8'd3, 8'd2, 12'h200, 1, 0, 0, 6, 6, "Rrrraaa",    12'h205);
        set_vec(3, 8'd4, 8'd2, 12'h020, 0, 1, 0, 8, 8, "Rrrrraaaa",  12'h027);
        set_vec(4, 8'd4, 8'd1, 12'hFFE, 0, 0, 0, 4, 4, "aaaa",       12'h001);
        set_vec(5, 8'd2, 8'd1, 12'h300, 0, 0, 1, 2, 2, "aa",         12'h301);

        // Reset state
        repeat (3) @(negedge clk);
        #2;
        check("reset_outputs", 32'(out_bundle()), 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        #2;
        check("idle_outputs", 32'(out_bundle()), 32'd0);

        // Table-driven passes
        for (int i = 0; i < 6; i++) run_pass(i);

        // Zero-sized configurations finish immediately without strobes
        for (int z = 0; z < 2; z++) begin
            @(negedge clk);
            clear_mon();
            exp_wbase   = 12'h0A0;
            cfg_acc_num = (z == 0) ? 8'd5 : 8'd0;
            cfg_row_num = (z == 0) ? 8'd0 : 8'd3;
            cfg_wbase   = 12'h0A0;
            start  = 1'b1;
            mon_en = 1'b1;
            @(negedge clk);
            start = 1'b0;
            #2;
            check($sformatf("zero%0d_done", z), 32'({done, busy}), 32'b10);
            @(negedge clk);
            #2;
            check($sformatf("zero%0d_done_clr", z), 32'(done), 32'd0);
            @(negedge clk);
            #3;
            mon_en = 1'b0;
            check($sformatf("zero%0d_strobes", z), 32'(n_lbuf + n_cmem), 32'd0);
            check_str($sformatf("zero%0d_seq", z), mon_log, "");
            $display("zero cfg %0d: acc=%0d row=%0d done_pulses=%0d", z, cfg_acc_num, cfg_row_num, n_done);
        end

        // Reset in the middle of RUN
        @(negedge clk);
        cfg_acc_num = 8'd4; cfg_row_num = 8'd2; cfg_wbase = 12'h040;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("midrst_in_run", 32'({busy, lbuf_ren, abuf_reuse_ren}), 32'b111);
        rstn = 1'b0;
        #1;
        check("midrst_outputs", 32'(out_bundle()), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        check("midrst_idle", 32'(out_bundle()), 32'd0);
        $display("mid-run reset: outputs cleared, sequencer idle");

        // Recovery pass after the reset
        run_pass(0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    // Absolute time bound in case a pass never completes.
    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
